// File: rtl/hack_dpram.sv
// Dual-port data memory for the Hack CPU: port A read/write, port B read-only,
// with an optional post-reset clear sequencer that zeroes the array before release.
module hack_dpram #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 14,
    parameter bit WRITE_FIRST    = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  b_valid,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   a_dout_q;
    logic [DATA_WIDTH-1:0]   b_dout_q;
    logic                    b_valid_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Single physical write port, shared between the clear sequencer and the CPU.
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    clearing;
    logic [DATA_WIDTH-1:0]   a_rdata_d;

    assign clearing = (state_q == ST_CLEAR);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = a_addr;
        wr_data = a_din;
        if (!rst) begin
            if (clearing) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = '0;
            end else begin
                wr_en   = a_we;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; zeroing is done by the sequencer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: reads here sample mem before this edge's write lands, which is what gives
    // read-first on port A and old-data on an A/B collision.
    always_comb begin
        a_rdata_d = mem[a_addr];
        if (WRITE_FIRST && a_we) begin
            a_rdata_d = a_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt_q     <= '0;
            busy_q    <= CLEAR_ON_RESET;
            a_dout_q  <= '0;
            b_dout_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q     <= cnt_q + ADDR_WIDTH'(1);
                    a_dout_q  <= '0;
                    b_valid_q <= 1'b0;
                    if (cnt_q == '1) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    a_dout_q <= a_rdata_d;
                    if (b_en) begin
                        b_dout_q  <= mem[b_addr];
                        b_valid_q <= 1'b1;
                    end else begin
                        b_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a_dout  = a_dout_q;
    assign b_dout  = b_dout_q;
    assign b_valid = b_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hack_dpram.sv
// Directed bench for hack_dpram at ADDR_WIDTH=4: a read-first and a write-first
// instance share the same stimulus so both read-during-write modes are observed.
module tb_hack_dpram;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          b_en;
    logic [AW-1:0] b_addr;

    logic [DW-1:0] a_dout_rf, b_dout_rf, a_dout_wf, b_dout_wf;
    logic          b_valid_rf, busy_rf, b_valid_wf, busy_wf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hack_dpram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)) dut_rf (
        .clk(clk), .rst(rst), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_rf),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout_rf), .b_valid(b_valid_rf), .busy(busy_rf)
    );

    hack_dpram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)) dut_wf (
        .clk(clk), .rst(rst), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout_wf),
        .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout_wf), .b_valid(b_valid_wf), .busy(busy_wf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge they were updated on.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the bus through a clear run until busy falls (bounded), optionally
    // attempting a CPU write to address 2 on clear cycle wr_cycle.
    task automatic run_clear(input int wr_cycle, output int cycles,
                             output logic saw_a, output logic saw_b);
        cycles = 0;
        saw_a  = 1'b0;
        saw_b  = 1'b0;
        while (busy_rf && cycles < 100) begin
            a_we   = (cycles + 1 == wr_cycle);
            a_addr = (cycles + 1 == wr_cycle) ? AW'(2) : AW'(9);
            a_din  = 16'hFFFF;
            b_en   = 1'b1;
            b_addr = AW'(cycles);
            step();
            cycles++;
            if (a_dout_rf !== '0 || a_dout_wf !== '0) saw_a = 1'b1;
            if (b_valid_rf !== 1'b0 || b_valid_wf !== 1'b0) saw_b = 1'b1;
        end
        a_we = 1'b0;
        b_en = 1'b0;
    endtask

    int   cyc;
    logic saw_a, saw_b;

    initial begin
        rst = 1'b1; a_we = 1'b0; a_addr = '0; a_din = '0; b_en = 1'b0; b_addr = '0;
        step();
        step();
        check("reset_a_dout", a_dout_rf, 0);
        check("reset_b_dout", b_dout_rf, 0);
        check("reset_b_valid", b_valid_rf, 0);
        check("reset_busy_rf", busy_rf, 1);
        check("reset_busy_wf", busy_wf, 1);

        // First clear with a write attempt at clear cycle 8.
        rst = 1'b0;
        run_clear(8, cyc, saw_a, saw_b);
        check("clear1_cycles", cyc, 16);
        check("clear1_busy_wf", busy_wf, 0);
        check("clear1_a_dout_zero", saw_a, 0);
        check("clear1_b_valid_zero", saw_b, 0);
        b_en = 1'b1; b_addr = AW'(2);
        step();
        b_en = 1'b0;
        check("clear_write_blocked", b_dout_rf, 16'h0000);
        check("clear_write_blocked_valid", b_valid_rf, 1);

        // Preload addr i with i*0x0101.
        for (int i = 0; i < 16; i++) begin
            a_we = 1'b1; a_addr = AW'(i); a_din = DW'(i * 16'h0101);
            step();
        end
        a_we = 1'b0;

        // Port B streaming over addresses 0..7.
        b_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_addr = AW'(i);
            step();
            check($sformatf("stream_valid_%0d", i), b_valid_rf, 1);
            check($sformatf("stream_data_%0d", i), b_dout_rf, i * 16'h0101);
        end
        b_en = 1'b0; b_addr = '0;
        step();
        check("stream_valid_fall", b_valid_rf, 0);
        check("stream_hold", b_dout_rf, 16'h0707);
        step();
        check("stream_hold2", b_dout_rf, 16'h0707);

        // Port A plain read.
        a_addr = AW'(9);
        step();
        check("a_read_9", a_dout_rf, 16'h0909);

        // Read-during-write on port A.
        a_we = 1'b1; a_addr = AW'(5); a_din = 16'h1234;
        step();
        a_din = 16'hBEEF;
        step();
        check("rdw_read_first", a_dout_rf, 16'h1234);
        check("rdw_write_first", a_dout_wf, 16'hBEEF);
        a_we = 1'b0;
        step();
        check("rdw_next_rf", a_dout_rf, 16'hBEEF);
        check("rdw_next_wf", a_dout_wf, 16'hBEEF);

        // A/B collision returns the old word on B in both modes.
        a_we = 1'b1; a_addr = AW'(3); a_din = 16'h00AA;
        step();
        a_din = 16'h0055; b_en = 1'b1; b_addr = AW'(3);
        step();
        check("collide_old_rf", b_dout_rf, 16'h00AA);
        check("collide_old_wf", b_dout_wf, 16'h00AA);
        check("collide_valid", b_valid_rf, 1);
        a_we = 1'b0;
        step();
        check("collide_next", b_dout_rf, 16'h0055);
        b_en = 1'b0;

        // Re-clear from READY, interrupted by rst at clear cycle 10.
        a_addr = AW'(9);
        rst = 1'b1;
        step();
        check("reclear_busy", busy_rf, 1);
        rst = 1'b0;
        repeat (10) step();
        check("midclear_busy", busy_rf, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_clear(0, cyc, saw_a, saw_b);
        check("clear2_cycles", cyc, 16);
        check("clear2_a_dout_zero", saw_a, 0);
        check("clear2_b_valid_zero", saw_b, 0);

        // Every word reads back as zero, one valid per request.
        b_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_addr = AW'(i);
            step();
            check($sformatf("zero_valid_%0d", i), b_valid_rf, 1);
            check($sformatf("zero_data_%0d", i), b_dout_wf, 16'h0000);
        end
        b_en = 1'b0;
        step();
        check("zero_valid_fall", b_valid_wf, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
